// File: rtl/debounce_filter.sv
// Multi-channel push-button debouncer: 2-flop synchroniser plus per-channel stability FSM.
// Optional long-press detector is built when DEBOUNCE_LONG_PRESS_EN is defined.
module debounce_filter #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 20,
  parameter int HOLD_CYCLES   = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pb_in,
  output logic [N_CH-1:0] pb_db,
  output logic [N_CH-1:0] pb_busy,
  output logic [N_CH-1:0] long_hold
);

  typedef enum logic {STABLE = 1'b0, CHECK = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam int CNT_MAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;

  if (STABLE_CYCLES < 2 || HOLD_CYCLES < 1 || CNT_W < 2 || CNT_W > 62 ||
      (64'(1) << CNT_W) <= 64'(CNT_MAX)) begin : g_param_check
    $error("debounce_filter: illegal parameter combination");
  end

  logic [N_CH-1:0] s1_p1;
  logic [N_CH-1:0] s2_p2;

  // Synchroniser stages: only s2_p2 is used downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_p1 <= '0;
      s2_p2 <= '0;
    end else begin
      s1_p1 <= pb_in;
      s2_p2 <= s1_p1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             db;
    logic             busy;
    logic             commit;

    // Qualification completes this cycle: input still differs and window is full
    assign commit = (state == CHECK) && (s2_p2[i] != db) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= STABLE;
        cnt   <= '0;
        db    <= 1'b0;
        busy  <= 1'b0;
      end else begin
        busy <= (state == CHECK);
        case (state)
          STABLE: begin
            cnt <= '0;
            if (s2_p2[i] != db) state <= CHECK;
          end
          CHECK: begin
            if (s2_p2[i] == db) begin
              state <= STABLE;
              cnt   <= '0;
            end else if (commit) begin
              db    <= s2_p2[i];
              state <= STABLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= STABLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign pb_db[i]   = db;
    assign pb_busy[i] = busy;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_FULL = CNT_W'(HOLD_CYCLES);

    logic [CNT_W-1:0] hold_cnt;
    logic             lh;

    // Hold counter pauses during CHECK and clears on the edge the level falls
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_cnt <= '0;
        lh       <= 1'b0;
      end else if (commit && !s2_p2[i]) begin
        hold_cnt <= '0;
        lh       <= 1'b0;
      end else if (state == STABLE && db) begin
        if (hold_cnt >= HOLD_LAST) lh <= 1'b1;
        if (hold_cnt != HOLD_FULL) hold_cnt <= hold_cnt + 1'b1;
      end
    end

    assign long_hold[i] = lh;
`else
    assign long_hold[i] = 1'b0;
`endif
  end

endmodule
